// File: rtl/status_counter_pkg.sv
// -----------------------------------------------------------------------------
// status_counter_pkg
// Shared definitions for the game-status block: play-state encoding, bit
// positions of the fields inside the 32-bit display word, BCD limits and the
// pending-points accumulator update.
// -----------------------------------------------------------------------------
package status_counter_pkg;

  // Play state; the encoding is visible on the `state` output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Field positions inside `num` = {level, time, score}.
  localparam int NUM_LEVEL_LSB = 24;  // 8-bit binary level
  localparam int NUM_TIME_LSB  = 16;  // 2-digit BCD timer
  localparam int NUM_SCORE_LSB = 0;   // 4-digit BCD score

  // BCD and binary limits.
  localparam logic [7:0]  BCD2_MAX    = 8'h99;
  localparam logic [15:0] BCD4_MAX    = 16'h9999;
  localparam logic [7:0]  LEVEL_MAX   = 8'd99;   // level is binary
  localparam logic [7:0]  PENDING_MAX = 8'hFF;

  // Pending points after one RUN cycle: absorb this cycle's points, give one
  // point to the score if any were waiting, saturate at 255. The subtraction
  // only happens when pending is non-zero, so the sum cannot underflow.
  function automatic logic [7:0] pending_next(input logic [7:0] pending,
                                               input logic [3:0] add);
    logic [8:0] sum;
    sum = {1'b0, pending} + {5'd0, add} - {8'd0, (pending != 8'd0)};
    return (sum > {1'b0, PENDING_MAX}) ? PENDING_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/status_counter_bcd_step.sv
// -----------------------------------------------------------------------------
// bcd_step
// Adds or subtracts one on a chain of BCD digits, rippling the carry/borrow
// from the least significant digit. The result saturates at the bound
// (all nines for increment, all zeros for decrement) instead of wrapping.
//
// Ports:
//   value    in  4*DIGITS  BCD operand
//   dec      in  1         0 = increment, 1 = decrement
//   result   out 4*DIGITS  stepped (saturated) value
//   at_limit out 1         result sits at the bound for this direction
// -----------------------------------------------------------------------------
module bcd_step #(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] value,
  input  logic                dec,
  output logic [4*DIGITS-1:0] result,
  output logic                at_limit
);

  always_comb begin : step
    logic       carry;
    logic [3:0] d;
    // NOTE: every variable assigned in always_comb gets a default first so
    // that no path leaves it unassigned and infers a latch.
    result = value;
    carry  = 1'b1;
    d      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (carry) begin
        if (dec) begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd9) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
        result[4*i +: 4] = d;
      end
    end
    // A carry out of the top digit means the operand was already at the
    // bound: hold it there.
    if (carry) result = value;
    at_limit = dec ? (result == '0) : (result == {DIGITS{4'h9}});
  end

endmodule

// File: rtl/status_counter.sv
// -----------------------------------------------------------------------------
// status_counter
// Game-status bookkeeping ahead of the seven-segment display stage. Holds the
// level, countdown timer and score, runs the idle/run/pause/over state
// machine and packs the fields into the display word. Added points are
// buffered and drained one per cycle so the score digits visibly roll.
//
// Optional feature: define STATUS_HISCORE_EN to add a high-score register
// that is captured when a game ends and shown while `show_hi` is high.
//
// Ports:
//   vga_clk  in  1   clock, rising edge
//   rst      in  1   synchronous active-high reset
//   start    in  1   pulse, start (or restart) a game
//   pause    in  1   pulse, toggle RUN/PAUSE
//   level_up in  1   pulse, next level (RUN only)
//   add_pts  in  4   binary points to add this cycle (RUN only)
//   show_hi  in  1   show high score in the score field (feature build only)
//   num      out 32  {level binary, time BCD, score BCD}, registered
//   state    out 2   0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   time_up  out 1   one-cycle pulse on the RUN->OVER transition
// -----------------------------------------------------------------------------
module status_counter
  import status_counter_pkg::*;
#(
  parameter int         CLK_HZ    = 25_000_000,
  parameter logic [7:0] TIME_INIT = 8'h60
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        level_up,
  input  logic [3:0]  add_pts,
  input  logic        show_hi,
  output logic [31:0] num,
  output logic [1:0]  state,
  output logic        time_up
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  state_e               state_q, state_d;
  logic [7:0]           level_q, level_d;
  logic [7:0]           time_q, time_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           pending_q, pending_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 time_up_q, time_up_d;
  logic [31:0]          num_q, num_d;
  logic [15:0]          score_field;

  logic [15:0]          score_inc;
  logic                 score_at_max;
  logic [7:0]           time_dec;
  logic                 time_at_zero;

  bcd_step #(.DIGITS(4)) u_score_inc (
    .value    (score_q),
    .dec      (1'b0),
    .result   (score_inc),
    .at_limit (score_at_max)
  );

  bcd_step #(.DIGITS(2)) u_time_dec (
    .value    (time_q),
    .dec      (1'b1),
    .result   (time_dec),
    .at_limit (time_at_zero)
  );

`ifdef STATUS_HISCORE_EN
  logic [15:0] hi_q, hi_d;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
`endif

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    time_d    = time_q;
    score_d   = score_q;
    pending_d = pending_q;
    presc_d   = presc_q;
    time_up_d = 1'b0;

    if (start) begin
      // Start wins over everything and behaves the same from every state.
      state_d   = ST_RUN;
      level_d   = 8'd1;
      time_d    = TIME_INIT;
      score_d   = '0;
      pending_d = '0;
      presc_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) state_d = ST_PAUSE;

          // Score drain: one point per cycle while points are waiting.
          if (pending_q != 8'd0) score_d = score_inc;
          if ((score_q == BCD4_MAX) || ((pending_q != 8'd0) && score_at_max))
            pending_d = '0;
          else
            pending_d = pending_next(pending_q, add_pts);

          // Timer: level_up reloads and restarts the second, otherwise the
          // prescaler wraps once per CLK_HZ run cycles.
          if (level_up) begin
            level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 8'd1;
            time_d  = TIME_INIT;
            presc_d = '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            time_d  = time_dec;
            if (time_at_zero) begin
              // Timing out beats a coincident pause; leftover points are
              // discarded.
              state_d   = ST_OVER;
              time_up_d = 1'b1;
              pending_d = '0;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        default: begin
          // IDLE and OVER only react to start.
        end
      endcase
    end

`ifdef STATUS_HISCORE_EN
    hi_d = hi_q;
    if (time_up_d && (score_d > hi_q)) hi_d = score_d;  // BCD orders like binary
    score_field = show_hi ? hi_d : score_d;
`else
    score_field = score_d;
`endif

    num_d = '0;
    num_d[NUM_LEVEL_LSB +: 8]  = level_d;
    num_d[NUM_TIME_LSB  +: 8]  = time_d;
    num_d[NUM_SCORE_LSB +: 16] = score_field;
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      level_q   <= 8'h00;
      time_q    <= TIME_INIT;
      score_q   <= 16'h0000;
      pending_q <= 8'h00;
      presc_q   <= '0;
      time_up_q <= 1'b0;
      num_q     <= {8'h00, TIME_INIT, 16'h0000};
`ifdef STATUS_HISCORE_EN
      hi_q      <= 16'h0000;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge.
      state_q   <= state_d;
      level_q   <= level_d;
      time_q    <= time_d;
      score_q   <= score_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      time_up_q <= time_up_d;
      num_q     <= num_d;
`ifdef STATUS_HISCORE_EN
      hi_q      <= hi_d;
`endif
    end
  end

  assign num     = num_q;
  assign state   = state_q;
  assign time_up = time_up_q;

endmodule

// File: tb/tb_status_counter.sv
// -----------------------------------------------------------------------------
// tb_status_counter
// Self-checking bench for status_counter with CLK_HZ=10, TIME_INIT=8'h03.
// A behavioural model tracks the game in plain integers (seconds left, score
// points, pending points) and a compare process checks every output on every
// falling edge; directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_status_counter;

  localparam int         CLK_HZ    = 10;
  localparam logic [7:0] TIME_INIT = 8'h03;
  localparam int         INIT_SECS = 10 * TIME_INIT[7:4] + TIME_INIT[3:0];

  logic        vga_clk = 1'b0;
  logic        rst, start, pause, level_up, show_hi;
  logic [3:0]  add_pts;
  logic [31:0] num;
  logic [1:0]  state;
  logic        time_up;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  status_counter #(.CLK_HZ(CLK_HZ), .TIME_INIT(TIME_INIT)) dut (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .level_up (level_up),
    .add_pts  (add_pts),
    .show_hi  (show_hi),
    .num      (num),
    .state    (state),
    .time_up  (time_up)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int m_state, m_level, m_secs, m_score, m_pend, m_ticks, m_hi;
  bit m_up, m_show;

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] model_num();
    logic [15:0] t, s;
    t = bcd4(m_secs);
    s = bcd4(m_score);
`ifdef STATUS_HISCORE_EN
    if (m_show) s = bcd4(m_hi);
`endif
    return {8'(m_level), t[7:0], s};
  endfunction

  always @(posedge vga_clk) begin : model
    int np;
    m_up = 1'b0;
    if (rst) begin
      m_state = 0; m_level = 0; m_secs = INIT_SECS; m_score = 0;
      m_pend = 0; m_ticks = 0; m_hi = 0;
    end else if (start) begin
      m_state = 1; m_level = 1; m_secs = INIT_SECS; m_score = 0;
      m_pend = 0; m_ticks = 0;
    end else if (m_state == 1) begin
      if (m_pend > 0 && m_score < 9999) m_score++;
      np = m_pend + int'(add_pts) - ((m_pend > 0) ? 1 : 0);
      if (np > 255) np = 255;
      if (m_score == 9999) np = 0;
      m_pend = np;
      if (pause) m_state = 2;
      if (level_up) begin
        m_level = (m_level < 99) ? m_level + 1 : 99;
        m_secs  = INIT_SECS;
        m_ticks = 0;
      end else begin
        m_ticks++;
        if (m_ticks == CLK_HZ) begin
          m_ticks = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_state = 3;
            m_up    = 1'b1;
            m_pend  = 0;
            if (m_score > m_hi) m_hi = m_score;
          end
        end
      end
    end else if (m_state == 2 && pause) begin
      m_state = 1;
    end
    m_show = show_hi;
  end

  always @(negedge vga_clk) begin
    if (cmp_en) begin
      check("model num", num, model_num());
      check("model state", 32'(state), 32'(m_state));
      check("model time_up", 32'(time_up), 32'(m_up));
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick(input int n = 1);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget,
                            input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; level_up = 1'b0;
    add_pts = 4'd0; show_hi = 1'b0;
    cmp_en = 1'b1;
    tick(2);
    rst = 1'b0;
    check("reset num", num, 32'h00030000);
    check("reset state", 32'(state), 32'd0);

    // Inputs other than start are ignored in IDLE.
    pause = 1'b1; level_up = 1'b1; add_pts = 4'd7;
    tick();
    pause = 1'b0; level_up = 1'b0; add_pts = 4'd0;
    tick();
    check("idle ignores", num, 32'h00030000);

    // Start, then let the timer run out.
    start = 1'b1; tick(); start = 1'b0;
    check("start num", num, 32'h01030000);
    check("start state", 32'(state), 32'd1);
    tick(10);
    check("time 02", num, 32'h01020000);
    tick(10);
    check("time 01", num, 32'h01010000);
    tick(10);
    check("time 00", num, 32'h01000000);
    check("over state", 32'(state), 32'd3);
    check("time_up pulse", 32'(time_up), 32'd1);
    tick();
    check("time_up cleared", 32'(time_up), 32'd0);
    add_pts = 4'd5; pause = 1'b1; level_up = 1'b1;
    tick();
    add_pts = 4'd0; pause = 1'b0; level_up = 1'b0;
    tick();
    check("over ignores num", num, 32'h01000000);
    check("over ignores state", 32'(state), 32'd3);

    // Buffered adds with a pause in the middle of the drain.
    start = 1'b1; tick(); start = 1'b0;
    add_pts = 4'd9; tick();
    add_pts = 4'd9; tick();
    add_pts = 4'd0; tick(3);
    pause = 1'b1; tick(); pause = 1'b0;
    tick(5);
    check("paused score", {16'h0, num[15:0]}, 32'h00000005);
    check("paused state", 32'(state), 32'd2);
    pause = 1'b1; tick(); pause = 1'b0;
    level_up = 1'b1; tick(); level_up = 1'b0;
    tick(20);
    check("drained score", {16'h0, num[15:0]}, 32'h00000018);
    check("drained state", 32'(state), 32'd1);

    // Coincident pulses.
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
    check("start+pause num", num, 32'h01030000);
    check("start+pause state", 32'(state), 32'd1);
    level_up = 1'b1; pause = 1'b1; tick(); level_up = 1'b0; pause = 1'b0;
    check("level_up+pause num", num, 32'h02030000);
    check("level_up+pause state", 32'(state), 32'd2);

    // Saturation of score and level.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10100; i++) begin
      add_pts  = 4'd15;
      level_up = (i % 20 == 19);
      tick();
    end
    add_pts = 4'd0; level_up = 1'b0;
    tick();
    check("score saturated", {16'h0, num[15:0]}, 32'h00009999);
    check("pending cleared", {24'h0, dut.pending_q}, 32'h0);
    tick(15);
    check("level 99 time 02", {16'h0, num[31:16]}, 32'h00006302);
    level_up = 1'b1; tick(); level_up = 1'b0;
    check("level 99 reload", {16'h0, num[31:16]}, 32'h00006303);

    // Reset overrides a coincident start.
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    check("rst over start num", num, 32'h00030000);
    check("rst over start state", 32'(state), 32'd0);

`ifdef STATUS_HISCORE_EN
    start = 1'b1; tick(); start = 1'b0;
    add_pts = 4'd15; tick();
    add_pts = 4'd15; tick();
    add_pts = 4'd12; tick();
    add_pts = 4'd0; tick(15);
    level_up = 1'b1; tick(); level_up = 1'b0;
    wait_state(2'd3, 60, "hs game1 over");
    check("hs game1 score", {16'h0, num[15:0]}, 32'h00000042);
    show_hi = 1'b1; tick();
    check("hs show 42", {16'h0, num[15:0]}, 32'h00000042);
    show_hi = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    add_pts = 4'd15; tick();
    add_pts = 4'd2; tick();
    add_pts = 4'd0;
    wait_state(2'd3, 60, "hs game2 over");
    check("hs game2 score", {16'h0, num[15:0]}, 32'h00000017);
    show_hi = 1'b1; tick();
    check("hs keeps 42", {16'h0, num[15:0]}, 32'h00000042);
    start = 1'b1; tick(); start = 1'b0;
    check("hs survives start", num, 32'h01030042);
    rst = 1'b1; tick(); rst = 1'b0;
    check("hs cleared by rst", {16'h0, num[15:0]}, 32'h00000000);
    show_hi = 1'b0;
    tick();
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
